// File: rtl/adc_link_pkg.sv
// -----------------------------------------------------------------------------
// adc_link_pkg
// Shared types and constants for the ADC link serializer.
//   link_state_t      : TRAIN / RUN line state
//   DEF_*             : default word width, training word, idle word and the
//                       number of training words per episode
//   PRBS7_TAPS/SEED   : PRBS-7 (x^7 + x^6 + 1) idle-fill generator constants
//   prbs7_step()      : one step of the PRBS-7 LFSR; the new bit lands in [0]
// -----------------------------------------------------------------------------
package adc_link_pkg;

   typedef enum logic {TRAIN, RUN} link_state_t;

   localparam int         DEF_WORD_W          = 8;
   localparam logic [7:0] DEF_TRAIN_PATTERN   = 8'hF0;
   localparam int         DEF_MIN_TRAIN_WORDS = 16;
   localparam logic [7:0] DEF_IDLE_WORD       = 8'h00;

   // Taps on stages 7 and 6 (bits 6 and 5 of the state vector).
   localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
   localparam logic [6:0] PRBS7_SEED = 7'h7F;

   function automatic logic [6:0] prbs7_step(input logic [6:0] s);
      return {s[5:0], ^(s & PRBS7_TAPS)};
   endfunction

endpackage

// File: rtl/adc_link_serializer_prbs7_gen.sv
// -----------------------------------------------------------------------------
// prbs7_gen
// PRBS-7 word source used as idle fill by adc_link_serializer.
// Only compiled when ADC_LINK_SER_PRBS_EN is defined.
//   CLK     : clock
//   RST     : synchronous active-high reset, reseeds the LFSR to 7'h7F
//   advance : consume the current word; the LFSR moves WORD_W steps on
//   word    : next WORD_W PRBS bits, first generated bit in the MSB
// -----------------------------------------------------------------------------
`ifdef ADC_LINK_SER_PRBS_EN
module prbs7_gen
   import adc_link_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              advance,
   output logic [WORD_W-1:0] word
);

   logic [6:0] lfsr_reg;
   logic [6:0] walk;

   // Unroll WORD_W LFSR steps; 'word' is a pure function of the state so the
   // serializer can load it in the same boundary cycle that advances it.
   always_comb begin
      walk = lfsr_reg;
      word = '0;
      for (int i = 0; i < WORD_W; i++) begin
         walk                = prbs7_step(walk);
         word[WORD_W-1-i]    = walk[0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         lfsr_reg <= PRBS7_SEED;
      end else if (advance) begin
         lfsr_reg <= walk;
      end
   end

endmodule
`endif

// File: rtl/adc_link_serializer.sv
// -----------------------------------------------------------------------------
// adc_link_serializer
// SDR serializer for an ADC-style LVDS lane. Parallel words arrive over a
// valid/ready handshake and leave MSB first, one bit per CLK, with a frame
// marker. A training word is repeated after reset and on request so the
// receiving deserializer can bitslip-align.
// Optional feature: define ADC_LINK_SER_PRBS_EN to fill idle words with PRBS-7
// instead of IDLE_WORD.
// Ports:
//   CLK, RST        : bit clock, synchronous active-high reset
//   s_data/s_valid  : parallel word in / valid
//   s_ready         : combinational, high only in accept (boundary) cycles
//   train_req       : level request to start or extend training
//   ser_o           : serial bit (registered)
//   frame_o         : high for the first WORD_W/2 bits of every word
//   word_start_o    : high on the first bit of every word
//   training_o      : high for all bits of a training word
//   underrun_cnt_o  : saturating count of idle words inserted in RUN
// -----------------------------------------------------------------------------
module adc_link_serializer
   import adc_link_pkg::*;
#(
   parameter int                WORD_W          = DEF_WORD_W,
   parameter logic [WORD_W-1:0] TRAIN_PATTERN   = WORD_W'(DEF_TRAIN_PATTERN),
   parameter int                MIN_TRAIN_WORDS = DEF_MIN_TRAIN_WORDS,
   parameter logic [WORD_W-1:0] IDLE_WORD       = WORD_W'(DEF_IDLE_WORD)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              train_req,
   output logic              ser_o,
   output logic              frame_o,
   output logic              word_start_o,
   output logic              training_o,
   output logic [15:0]       underrun_cnt_o
);

   localparam int                CNT_W      = $clog2(WORD_W);
   localparam int                TCNT_W     = $clog2(MIN_TRAIN_WORDS + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]  HALF_BITS  = CNT_W'(WORD_W / 2);
   localparam logic [TCNT_W-1:0] TRAIN_DONE = TCNT_W'(MIN_TRAIN_WORDS);

   link_state_t       state_reg, state_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [TCNT_W-1:0] train_cnt_reg, train_cnt_next;
   logic [WORD_W-1:0] shreg_reg;
   logic              train_pend_reg;

   logic              boundary;
   logic              train_req_eff;
   logic              load_train;
   logic              xfer;
   logic              idle_load;
   logic [WORD_W-1:0] idle_word;
   logic [WORD_W-1:0] load_word;

`ifdef ADC_LINK_SER_PRBS_EN
   prbs7_gen #(
      .WORD_W (WORD_W)
   ) u_prbs (
      .CLK     (CLK),
      .RST     (RST),
      .advance (idle_load),
      .word    (idle_word)
   );
`else
   assign idle_word = IDLE_WORD;
`endif

   assign boundary = (bit_cnt_reg == LAST_BIT);

   // A train_req pulse that comes and goes mid-word is remembered until the
   // next boundary, so a short request is never lost. The same effective
   // request gates s_ready, which keeps a word from being accepted in the
   // boundary where the line turns to training.
   assign train_req_eff = train_req | train_pend_reg;

   assign s_ready = boundary & ~train_req_eff &
                    ((state_reg == RUN) | (train_cnt_reg == TRAIN_DONE));

   assign xfer      = s_valid & s_ready;
   assign idle_load = boundary & ~load_train & ~xfer;
   assign load_word = load_train ? TRAIN_PATTERN : (xfer ? s_data : idle_word);

   assign bit_cnt_next = boundary ? '0 : bit_cnt_reg + CNT_W'(1);

   // Next-state logic; decisions are only taken at word boundaries.
   always_comb begin
      state_next     = state_reg;
      train_cnt_next = train_cnt_reg;
      load_train     = 1'b0;
      if (boundary) begin
         unique case (state_reg)
            TRAIN: begin
               if (train_req_eff) begin
                  load_train     = 1'b1;
                  train_cnt_next = TCNT_W'(1);
               end else if (train_cnt_reg < TRAIN_DONE) begin
                  load_train     = 1'b1;
                  train_cnt_next = train_cnt_reg + TCNT_W'(1);
               end else begin
                  // Episode complete: the data/idle word goes out this boundary.
                  state_next = RUN;
               end
            end
            RUN: begin
               if (train_req_eff) begin
                  state_next     = TRAIN;
                  load_train     = 1'b1;
                  train_cnt_next = TCNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // At a boundary the MSB of the new word goes straight to ser_o and the rest
   // is parked in shreg, so the MSB appears the cycle after acceptance and the
   // LSB is on the line during the next boundary cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg      <= TRAIN;
         bit_cnt_reg    <= LAST_BIT;
         train_cnt_reg  <= '0;
         shreg_reg      <= '0;
         train_pend_reg <= 1'b0;
         ser_o          <= 1'b0;
         frame_o        <= 1'b0;
         word_start_o   <= 1'b0;
         training_o     <= 1'b0;
         underrun_cnt_o <= '0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         train_cnt_reg  <= train_cnt_next;
         train_pend_reg <= boundary ? 1'b0 : (train_pend_reg | train_req);
         word_start_o   <= boundary;
         frame_o        <= (bit_cnt_next < HALF_BITS);
         if (boundary) begin
            ser_o      <= load_word[WORD_W-1];
            shreg_reg  <= {load_word[WORD_W-2:0], 1'b0};
            training_o <= load_train;
         end else begin
            ser_o      <= shreg_reg[WORD_W-1];
            shreg_reg  <= {shreg_reg[WORD_W-2:0], 1'b0};
         end
         if (idle_load && (underrun_cnt_o != 16'hFFFF)) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_link_serializer.sv
// -----------------------------------------------------------------------------
// tb_adc_link_serializer
// Self-checking bench for adc_link_serializer (WORD_W = 8).
// A word-level reference model predicts every output each cycle; directed
// sequences cover training after reset, back-to-back streaming, a mid-word
// train request, a held train request, reset mid-word, random traffic and a
// bitslip-locking loopback receiver.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_link_serializer;

   localparam int         W    = 8;
   localparam int         MINT = 16;
   localparam logic [7:0] TP   = 8'hF0;
   localparam logic [7:0] IW   = 8'h00;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic [7:0]  s_data    = '0;
   logic        s_valid   = 1'b0;
   logic        train_req = 1'b0;
   logic        s_ready;
   logic        ser_o;
   logic        frame_o;
   logic        word_start_o;
   logic        training_o;
   logic [15:0] underrun_cnt_o;

   int checks   = 0;
   int failures = 0;

   adc_link_serializer #(
      .WORD_W          (W),
      .TRAIN_PATTERN   (TP),
      .MIN_TRAIN_WORDS (MINT),
      .IDLE_WORD       (IW)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .s_data         (s_data),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .train_req      (train_req),
      .ser_o          (ser_o),
      .frame_o        (frame_o),
      .word_start_o   (word_start_o),
      .training_o     (training_o),
      .underrun_cnt_o (underrun_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int limit, output int n);
      n = 0;
      while (!s_ready && n < limit) begin
         tick();
         n++;
      end
   endtask

   // ---------------- word-level reference model ----------------
   bit         m_on_line;   // a word is being shown on the line
   logic [7:0] m_word;
   int         m_idx;       // bit index of the word shown, 0 = MSB
   bit         m_is_train;
   bit         m_in_train;
   int         m_tcnt;
   bit         m_pend;
   int         m_under;
   int         m_prbs;
   bit         chk_en = 1'b0;

   function automatic void model_reset();
      m_on_line  = 1'b0;
      m_word     = '0;
      m_idx      = 0;
      m_is_train = 1'b0;
      m_in_train = 1'b1;
      m_tcnt     = 0;
      m_pend     = 1'b0;
      m_under    = 0;
      m_prbs     = 'h7F;
   endfunction

   function automatic logic [7:0] next_idle();
`ifdef ADC_LINK_SER_PRBS_EN
      logic [7:0] w;
      int nb;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         nb     = ((m_prbs >> 6) & 1) ^ ((m_prbs >> 5) & 1);
         m_prbs = ((m_prbs * 2) + nb) % 128;
         w      = {w[6:0], nb[0]};
      end
      return w;
`else
      return IW;
`endif
   endfunction

   function automatic bit model_slot_end();
      return !m_on_line || (m_idx == W - 1);
   endfunction

   function automatic bit model_ready(input bit tr);
      return model_slot_end() && !(tr || m_pend) && (!m_in_train || m_tcnt == MINT);
   endfunction

   function automatic void model_step(input bit r, input bit tr, input bit v, input logic [7:0] d);
      bit req;
      if (r) begin
         model_reset();
         return;
      end
      req = tr || m_pend;
      if (!model_slot_end()) begin
         m_idx++;
         m_pend = req;
         return;
      end
      m_pend    = 1'b0;
      m_on_line = 1'b1;
      m_idx     = 0;
      if (req) begin
         m_in_train = 1'b1;
         m_tcnt     = 1;
         m_word     = TP;
         m_is_train = 1'b1;
      end else if (m_in_train && m_tcnt < MINT) begin
         m_tcnt++;
         m_word     = TP;
         m_is_train = 1'b1;
      end else begin
         m_in_train = 1'b0;
         m_is_train = 1'b0;
         if (v) begin
            m_word = d;
         end else begin
            m_word = next_idle();
            if (m_under < 65535) m_under++;
         end
      end
   endfunction

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ser_o",        ser_o,        m_on_line ? 32'(m_word[W-1-m_idx]) : 32'd0);
         check("frame_o",      frame_o,      32'(m_on_line && m_idx < W/2));
         check("word_start_o", word_start_o, 32'(m_on_line && m_idx == 0));
         check("training_o",   training_o,   32'(m_on_line && m_is_train));
         check("underrun_cnt", underrun_cnt_o, 32'(m_under));
         check("s_ready",      s_ready,      32'(model_ready(train_req)));
         model_step(rst, train_req, s_valid, s_data);
      end
   end

   // ---------------- word capture from the line ----------------
   typedef struct {
      logic [7:0] data;
      logic [7:0] frame;
      logic [7:0] ws;
      bit         train;
   } cap_t;
   cap_t       cap_q[$];
   logic [7:0] cd, cf, cw;
   bit         ct;
   int         cn = -1;

   always @(negedge clk) begin
      if (word_start_o) begin
         cd = '0; cf = '0; cw = '0; cn = 0; ct = training_o;
      end
      if (cn >= 0) begin
         cd = {cd[6:0], ser_o};
         cf = {cf[6:0], frame_o};
         cw = {cw[6:0], word_start_o};
         cn++;
         if (cn == W) begin
            cap_q.push_back('{cd, cf, cw, ct});
            $display("word data=%02h frame=%02h ws=%02h train=%0d", cd, cf, cw, ct);
            cn = -1;
         end
      end
   end

   // ---------------- loopback receiver with bitslip search ----------------
   bit         rx_en = 1'b0;
   logic [7:0] rx_sh = '0;
   int         rx_cyc = 0;
   int         rx_cand = -1;
   int         rx_hits = 0;
   int         rx_phase = -1;
   bit         rx_started = 1'b0;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (rx_en) begin
         rx_sh = {rx_sh[6:0], ser_o};
         rx_cyc++;
         if (rx_phase < 0) begin
            if (rx_sh == TP) begin
               if (rx_cyc % W == rx_cand) rx_hits++;
               else begin
                  rx_cand = rx_cyc % W;
                  rx_hits = 1;
               end
               if (rx_hits >= 4) rx_phase = rx_cand;
            end
         end else if (rx_cyc % W == rx_phase) begin
            if (!rx_started && rx_sh != TP) rx_started = 1'b1;
            if (rx_started) rx_q.push_back(rx_sh);
         end
      end
   end

   // ---------------- table of back-to-back stream vectors ----------------
   typedef struct {
      logic [7:0] din;
      logic [7:0] exp_bits;
      logic [7:0] exp_frame;
      logic [7:0] exp_ws;
      bit         exp_train;
   } vec_t;
   vec_t tbl[6];

   function automatic int find_data(input logic [7:0] d, input bit train);
      foreach (cap_q[i])
         if (cap_q[i].data == d && cap_q[i].train == train) return i;
      return -1;
   endfunction

   initial begin
      int n;
      int k;
      int run;

      tbl[0] = '{8'hA5, 8'b1010_0101, 8'b1111_0000, 8'b1000_0000, 1'b0};
      tbl[1] = '{8'h3C, 8'b0011_1100, 8'b1111_0000, 8'b1000_0000, 1'b0};
      tbl[2] = '{8'h81, 8'b1000_0001, 8'b1111_0000, 8'b1000_0000, 1'b0};
      tbl[3] = '{8'hFF, 8'b1111_1111, 8'b1111_0000, 8'b1000_0000, 1'b0};
      tbl[4] = '{8'h00, 8'b0000_0000, 8'b1111_0000, 8'b1000_0000, 1'b0};
      tbl[5] = '{8'h5A, 8'b0101_1010, 8'b1111_0000, 8'b1000_0000, 1'b0};

      // ---- reset state ----
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk_en = 1'b1;
      check("rst_ser_o",    ser_o, 0);
      check("rst_frame_o",  frame_o, 0);
      check("rst_ws",       word_start_o, 0);
      check("rst_training", training_o, 0);
      check("rst_underrun", underrun_cnt_o, 0);
      tick();
      rst = 1'b0;

      // ---- training after reset, then idle words ----
      wait_ready(400, n);
      check("first_ready_cycle", n, 128);
      check("first_ready", s_ready, 1);
      repeat (24) tick();
      check("idle_underrun", underrun_cnt_o, 3);

      // ---- back-to-back stream from the vector table ----
      cap_q.delete();
      s_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         s_data = tbl[i].din;
         wait_ready(16, n);
         check("stream_ready", s_ready, 1);
         tick();
      end
      check("stream_underrun", underrun_cnt_o, 3);
      s_valid = 1'b0;
      repeat (12) tick();
      k = find_data(8'hA5, 1'b0);
      check("stream_found", 32'(k >= 0), 1);
      if (k >= 0) begin
         for (int i = 0; i < 6; i++) begin
            if (k + i < cap_q.size()) begin
               check("stream_bits",  cap_q[k+i].data,  tbl[i].exp_bits);
               check("stream_frame", cap_q[k+i].frame, tbl[i].exp_frame);
               check("stream_ws",    cap_q[k+i].ws,    tbl[i].exp_ws);
               check("stream_train", cap_q[k+i].train, tbl[i].exp_train);
            end else begin
               check("stream_len", k + i, cap_q.size() - 1);
            end
         end
      end

      // ---- train_req pulse at bit 3 of 8'hA5 ----
      cap_q.delete();
      s_valid = 1'b1;
      s_data  = 8'hA5;
      wait_ready(16, n);
      check("pulse_ready", s_ready, 1);
      tick();
      s_data = 8'h3C;
      repeat (3) tick();
      train_req = 1'b1;
      tick();
      train_req = 1'b0;
      wait_ready(200, n);
      check("pulse_resume_ready", s_ready, 1);
      tick();
      s_valid = 1'b0;
      repeat (12) tick();
      k = find_data(8'hA5, 1'b0);
      check("pulse_found", 32'(k >= 0), 1);
      if (k >= 0) begin
         run = 0;
         while (k + 1 + run < cap_q.size() && cap_q[k+1+run].train && cap_q[k+1+run].data == TP) run++;
         check("pulse_train_words", run, 16);
         if (k + 1 + run < cap_q.size()) check("pulse_next_data", cap_q[k+1+run].data, 8'h3C);
         else check("pulse_next_present", 0, 1);
      end

      // ---- train_req held for 40 training words ----
      cap_q.delete();
      s_valid = 1'b1;
      s_data  = 8'h5A;
      wait_ready(16, n);
      check("hold_ready", s_ready, 1);
      tick();
      s_valid   = 1'b0;
      train_req = 1'b1;
      repeat (W + 40 * W) tick();
      train_req = 1'b0;
      repeat (20 * W) tick();
      k = find_data(8'h5A, 1'b0);
      check("hold_found", 32'(k >= 0), 1);
      if (k >= 0) begin
         run = 0;
         while (k + 1 + run < cap_q.size() && cap_q[k+1+run].train) run++;
         check("hold_train_words", run, 56);
         if (k + 1 + run < cap_q.size()) check("hold_after_idle", cap_q[k+1+run].data, IW);
      end

      // ---- reset at bit 5 of 8'hFF ----
      s_valid = 1'b1;
      s_data  = 8'hFF;
      wait_ready(16, n);
      check("rstmid_ready", s_ready, 1);
      tick();
      s_valid = 1'b0;
      repeat (5) tick();
      check("rstmid_ser_before", ser_o, 1);
      rst = 1'b1;
      tick();
      check("rstmid_ser_o",    ser_o, 0);
      check("rstmid_frame_o",  frame_o, 0);
      check("rstmid_underrun", underrun_cnt_o, 0);
      check("rstmid_training", training_o, 0);
      rst = 1'b0;
      wait_ready(400, n);
      check("rstmid_retrain_cycles", n, 128);

      // ---- random traffic against the model ----
      for (int i = 0; i < 800; i++) begin
         s_valid   = ($urandom_range(0, 3) != 0);
         s_data    = 8'($urandom);
         train_req = ($urandom_range(0, 99) == 0);
         rst       = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0; train_req = 1'b0; s_valid = 1'b0;

      // ---- loopback: lock on training, then receive 8'h00..8'hFF ----
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      rx_en = 1'b1;
      s_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         s_data = 8'(i);
         wait_ready(200, n);
         if (!s_ready) begin
            check("loop_ready", s_ready, 1);
            break;
         end
         tick();
      end
      s_valid = 1'b0;
      repeat (3 * W) tick();
      check("loop_locked", 32'(rx_phase >= 0), 1);
      check("loop_count", 32'(rx_q.size() >= 256), 1);
      for (int i = 0; i < 256 && i < rx_q.size(); i++)
         check("loop_word", rx_q[i], 32'(i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
